// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// misaligned-branch pulse and a saturating count of instructions handed to decode.
module fetch_pipe #(
  parameter int unsigned  N         = 64,
  parameter logic [N-1:0] RESET_VEC = '0,
  parameter logic [N-1:0] EXC_VEC   = N'('hD8),
  parameter int unsigned  CNTW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc_F,
  input  logic [N-1:0]    PCBranch_F,
  input  logic            Exc_F,
  input  logic            Stall_F,
  input  logic [31:0]     imem_data_F,
  output logic [N-1:0]    imem_addr_F,
  output logic [31:0]     instr_D,
  output logic [N-1:0]    pc_D,
  output logic            valid_D,
  output logic            misalign_F,
  output logic [CNTW-1:0] fetch_count_F
);

  logic [N-1:0]    pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [N-1:0]    dpc_q, dpc_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic [CNTW-1:0] count_q, count_d;

  logic redirect;
  logic bad_target;

  assign redirect   = Exc_F | PCSrc_F;
  // An exception masks the branch entirely, so its target alignment is irrelevant.
  assign bad_target = PCSrc_F & ~Exc_F & (|PCBranch_F[1:0]);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    pc_d       = pc_q;
    instr_d    = instr_q;
    dpc_d      = dpc_q;
    valid_d    = valid_q;
    misalign_d = bad_target;
    count_d    = count_q;

    if (Exc_F || bad_target) begin
      pc_d = EXC_VEC;
    end else if (PCSrc_F) begin
      pc_d = PCBranch_F;
    end else if (!Stall_F) begin
      pc_d = pc_q + N'(4);
    end

    // A flush only kills valid; the stale payload is left in place.
    if (redirect) begin
      valid_d = 1'b0;
    end else if (!Stall_F) begin
      instr_d = imem_data_F;
      dpc_d   = pc_q;
      valid_d = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + CNTW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      instr_q    <= '0;
      dpc_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      dpc_q      <= dpc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_F   = pc_q;
  assign instr_D       = instr_q;
  assign pc_D          = dpc_q;
  assign valid_D       = valid_q;
  assign misalign_F    = misalign_q;
  assign fetch_count_F = count_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe: a default 64-bit instance plus a narrow
// N=8 / CNTW=2 instance for address wrap and counter saturation.
module tb_fetch_pipe;

  localparam logic [31:0] PAT = 32'hC0DE_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        reset = 1'b1;
  logic        pcsrc = 1'b0, exc = 1'b0, stall = 1'b0;
  logic [63:0] branch = '0;
  logic [31:0] imem_data;
  logic [63:0] imem_addr, pc_d;
  logic [31:0] instr_d;
  logic        valid_d, misalign;
  logic [15:0] count;

  assign imem_data = imem_addr[31:0] ^ PAT;

  fetch_pipe dut (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch), .Exc_F(exc),
    .Stall_F(stall), .imem_data_F(imem_data), .imem_addr_F(imem_addr),
    .instr_D(instr_d), .pc_D(pc_d), .valid_D(valid_d), .misalign_F(misalign),
    .fetch_count_F(count)
  );

  // Narrow instance
  logic        s_reset = 1'b1;
  logic [7:0]  s_branch = '0;
  logic [31:0] s_imem_data;
  logic [7:0]  s_addr, s_pc_d;
  logic [31:0] s_instr_d;
  logic        s_valid_d, s_misalign;
  logic [1:0]  s_count;

  assign s_imem_data = {24'h0, s_addr} ^ PAT;

  fetch_pipe #(.N(8), .RESET_VEC(8'hF8), .EXC_VEC(8'hD8), .CNTW(2)) dut_s (
    .clk(clk), .reset(s_reset), .PCSrc_F(1'b0), .PCBranch_F(s_branch), .Exc_F(1'b0),
    .Stall_F(1'b0), .imem_data_F(s_imem_data), .imem_addr_F(s_addr),
    .instr_D(s_instr_d), .pc_D(s_pc_d), .valid_D(s_valid_d), .misalign_F(s_misalign),
    .fetch_count_F(s_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pcsrc = 1'b1; exc = 1'b1; stall = 1'b1; branch = 64'h1234;
    repeat (5) step();
    n_vec++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr: got %0h expected 0", imem_addr); end
    n_vec++; if (instr_d !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %0h expected 0", instr_d); end
    n_vec++; if (pc_d !== 64'h0) begin n_err++; $display("FAIL rst_pc_d: got %0h expected 0", pc_d); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", valid_d); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %0b expected 0", misalign); end
    n_vec++; if (count !== 16'h0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
    pcsrc = 1'b0; exc = 1'b0; stall = 1'b0; branch = '0;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_vec++; if (imem_addr !== 64'(4 * k)) begin n_err++; $display("FAIL seq_addr[%0d]: got %0h expected %0h", k, imem_addr, 4 * k); end
      n_vec++; if (pc_d !== 64'(4 * (k - 1))) begin n_err++; $display("FAIL seq_pc_d[%0d]: got %0h expected %0h", k, pc_d, 4 * (k - 1)); end
      n_vec++; if (valid_d !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %0b expected 1", k, valid_d); end
      n_vec++; if (count !== 16'(k)) begin n_err++; $display("FAIL seq_count[%0d]: got %0d expected %0d", k, count, k); end
    end
    n_vec++; if (instr_d !== (32'hC ^ PAT)) begin n_err++; $display("FAIL seq_instr: got %0h expected %0h", instr_d, 32'hC ^ PAT); end
  endtask

  task automatic test_branch();
    pcsrc = 1'b1; branch = 64'hAA8;
    step();
    pcsrc = 1'b0; branch = '0;
    n_vec++; if (imem_addr !== 64'hAA8) begin n_err++; $display("FAIL br_addr: got %0h expected aa8", imem_addr); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL br_flush: got %0b expected 0", valid_d); end
    n_vec++; if (pc_d !== 64'hC) begin n_err++; $display("FAIL br_pc_hold: got %0h expected c", pc_d); end
    n_vec++; if (count !== 16'd4) begin n_err++; $display("FAIL br_count: got %0d expected 4", count); end
    step();
    n_vec++; if (pc_d !== 64'hAA8) begin n_err++; $display("FAIL br_pc_d: got %0h expected aa8", pc_d); end
    n_vec++; if (imem_addr !== 64'hAAC) begin n_err++; $display("FAIL br_next: got %0h expected aac", imem_addr); end
    n_vec++; if (instr_d !== (32'hAA8 ^ PAT)) begin n_err++; $display("FAIL br_instr: got %0h expected %0h", instr_d, 32'hAA8 ^ PAT); end
    n_vec++; if (count !== 16'd5) begin n_err++; $display("FAIL br_count2: got %0d expected 5", count); end
  endtask

  task automatic test_misalign();
    pcsrc = 1'b1; branch = 64'hAAA;
    step();
    pcsrc = 1'b0; branch = '0;
    n_vec++; if (imem_addr !== 64'hD8) begin n_err++; $display("FAIL mis_addr: got %0h expected d8", imem_addr); end
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %0b expected 1", misalign); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL mis_flush: got %0b expected 0", valid_d); end
    step();
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %0b expected 0", misalign); end
    n_vec++; if (imem_addr !== 64'hDC) begin n_err++; $display("FAIL mis_next: got %0h expected dc", imem_addr); end
    n_vec++; if (count !== 16'd6) begin n_err++; $display("FAIL mis_count: got %0d expected 6", count); end
    pcsrc = 1'b1; exc = 1'b1; branch = 64'hAAA;
    step();
    pcsrc = 1'b0; exc = 1'b0; branch = '0;
    n_vec++; if (imem_addr !== 64'hD8) begin n_err++; $display("FAIL exc_br_addr: got %0h expected d8", imem_addr); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL exc_br_misalign: got %0b expected 0", misalign); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL exc_br_flush: got %0b expected 0", valid_d); end
    step();
    n_vec++; if (count !== 16'd7) begin n_err++; $display("FAIL exc_br_count: got %0d expected 7", count); end
  endtask

  task automatic test_stall();
    pcsrc = 1'b1; branch = 64'h1C;
    step();
    pcsrc = 1'b0; branch = '0;
    step();
    n_vec++; if (imem_addr !== 64'h20) begin n_err++; $display("FAIL st_setup: got %0h expected 20", imem_addr); end
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++; if (imem_addr !== 64'h20) begin n_err++; $display("FAIL st_addr[%0d]: got %0h expected 20", k, imem_addr); end
      n_vec++; if (pc_d !== 64'h1C) begin n_err++; $display("FAIL st_pc_d[%0d]: got %0h expected 1c", k, pc_d); end
      n_vec++; if (instr_d !== (32'h1C ^ PAT)) begin n_err++; $display("FAIL st_instr[%0d]: got %0h expected %0h", k, instr_d, 32'h1C ^ PAT); end
      n_vec++; if (count !== 16'd8) begin n_err++; $display("FAIL st_count[%0d]: got %0d expected 8", k, count); end
      n_vec++; if (valid_d !== 1'b1) begin n_err++; $display("FAIL st_valid[%0d]: got %0b expected 1", k, valid_d); end
    end
    exc = 1'b1;
    step();
    exc = 1'b0; stall = 1'b0;
    n_vec++; if (imem_addr !== 64'hD8) begin n_err++; $display("FAIL st_exc_addr: got %0h expected d8", imem_addr); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL st_exc_flush: got %0b expected 0", valid_d); end
    n_vec++; if (count !== 16'd8) begin n_err++; $display("FAIL st_exc_count: got %0d expected 8", count); end
    step();
    n_vec++; if (pc_d !== 64'hD8) begin n_err++; $display("FAIL st_resume: got %0h expected d8", pc_d); end
    n_vec++; if (count !== 16'd9) begin n_err++; $display("FAIL st_resume_count: got %0d expected 9", count); end
  endtask

  task automatic test_async_reset();
    pcsrc = 1'b1; branch = 64'h3C;
    step();
    pcsrc = 1'b0; branch = '0;
    step();
    n_vec++; if (imem_addr !== 64'h40) begin n_err++; $display("FAIL ar_setup: got %0h expected 40", imem_addr); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL ar_addr: got %0h expected 0", imem_addr); end
    n_vec++; if (pc_d !== 64'h0) begin n_err++; $display("FAIL ar_pc_d: got %0h expected 0", pc_d); end
    n_vec++; if (instr_d !== 32'h0) begin n_err++; $display("FAIL ar_instr: got %0h expected 0", instr_d); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b expected 0", valid_d); end
    n_vec++; if (count !== 16'h0) begin n_err++; $display("FAIL ar_count: got %0d expected 0", count); end
    repeat (2) step();
    n_vec++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL ar_hold: got %0h expected 0", imem_addr); end
    reset = 1'b0;
    step();
    n_vec++; if (imem_addr !== 64'h4) begin n_err++; $display("FAIL ar_resume_addr: got %0h expected 4", imem_addr); end
    n_vec++; if (pc_d !== 64'h0 || valid_d !== 1'b1) begin n_err++; $display("FAIL ar_resume_d: got pc_d=%0h valid=%0b expected pc_d=0 valid=1", pc_d, valid_d); end
    n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL ar_resume_count: got %0d expected 1", count); end
  endtask

  task automatic test_wrap_saturate();
    logic [7:0] exp_a [4];
    logic [1:0] exp_c [4];
    exp_a = '{8'hFC, 8'h00, 8'h04, 8'h08};
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3};
    n_vec++; if (s_addr !== 8'hF8) begin n_err++; $display("FAIL nr_rst_addr: got %0h expected f8", s_addr); end
    s_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++; if (s_addr !== exp_a[k]) begin n_err++; $display("FAIL nr_addr[%0d]: got %0h expected %0h", k, s_addr, exp_a[k]); end
      n_vec++; if (s_count !== exp_c[k]) begin n_err++; $display("FAIL nr_count[%0d]: got %0d expected %0d", k, s_count, exp_c[k]); end
    end
    n_vec++; if (s_pc_d !== 8'h04 || s_valid_d !== 1'b1) begin n_err++; $display("FAIL nr_pc_d: got pc_d=%0h valid=%0b expected pc_d=4 valid=1", s_pc_d, s_valid_d); end
    n_vec++; if (s_misalign !== 1'b0) begin n_err++; $display("FAIL nr_misalign: got %0b expected 0", s_misalign); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misalign();
    test_stall();
    test_async_reset();
    test_wrap_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
